line_mem_ctrl: RTL and testbench

- Backing-store controller directly downstream of the data cache unit (cmu).
- Serves whole-line refill reads and write-backs as fixed-length bursts, one 32-bit word per cycle, after a programmable access latency.
- Holds the data memory array internally and replaces the single-cycle data RAM behind the cache.
- Drives busy/done status so the cache FSM can sequence refills and write-backs.

---
 rtl/line_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_line_mem_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - line-burst backing-store controller behind the data cache
// Serves refill and write-back bursts of whole lines after a fixed access latency.
module line_mem_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 4,
  localparam int BEAT_W        = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ack,
  input  logic [31:0]           wdata,
  output logic                  wdata_rdy,
  output logic [31:0]           rdata,
  output logic                  rdata_vld,
  output logic [BEAT_W-1:0]     beat_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int LINE_W = MEM_WORDS_LOG2 - BEAT_W;
  localparam int LAT_W  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0]  WAIT_INIT = LAT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BEAT, DONE} state_t;

  state_t            state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LINE_W-1:0] base_line;
  logic              we_q;
  logic [31:0]       mem [0:(1<<MEM_WORDS_LOG2)-1];
  logic [31:0]       ram_q;
  logic [LINE_W-1:0] rd_line;
  logic [BEAT_W-1:0] rd_idx;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:MEM_WORDS_LOG2], req_addr[BEAT_W-1:0]};

  // Read address runs one beat ahead so each beat's word is already registered.
  always_comb begin
    rd_line = (state == IDLE) ? req_addr[MEM_WORDS_LOG2-1:BEAT_W] : base_line;
    rd_idx  = (state == BEAT) ? beat_idx + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (wdata_rdy) begin
      mem[{base_line, beat_idx}] <= wdata;
    end
    ram_q <= mem[{rd_line, rd_idx}];
  end

  assign rdata = rdata_vld ? ram_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      base_line <= '0;
      we_q      <= 1'b0;
      req_ack   <= 1'b0;
      wdata_rdy <= 1'b0;
      rdata_vld <= 1'b0;
      beat_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      req_ack <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (req) begin
            base_line <= req_addr[MEM_WORDS_LOG2-1:BEAT_W];
            we_q      <= req_we;
            req_ack   <= 1'b1;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state     <= BEAT;
              wdata_rdy <= req_we;
              rdata_vld <= !req_we;
            end else begin
              state   <= WAIT;
              lat_cnt <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state     <= BEAT;
            wdata_rdy <= we_q;
            rdata_vld <= !we_q;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        BEAT: begin
          if (beat_idx == LAST_BEAT) begin
            state     <= DONE;
            wdata_rdy <= 1'b0;
            rdata_vld <= 1'b0;
            beat_idx  <= '0;
            done      <= 1'b1;
          end else begin
            beat_idx <= beat_idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb/tb_line_mem_ctrl.sv - randomized self-checking bench for line_mem_ctrl
// Two instances: LATENCY=4 (sel 0) and LATENCY=1 (sel 1), sharing clock and reset.
module tb_line_mem_ctrl;

  localparam int WPL       = 4;
  localparam int MWL       = 10;
  localparam int MEM_WORDS = 1 << MWL;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req       [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] wdata     [2];
  logic        req_ack   [2];
  logic        wdata_rdy [2];
  logic [31:0] rdata     [2];
  logic        rdata_vld [2];
  logic [1:0]  beat_idx  [2];
  logic        busy      [2];
  logic        done      [2];

  logic [31:0] model [2][MEM_WORDS];
  logic [31:0] wbuf  [WPL];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  line_mem_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_LINE(WPL), .MEM_WORDS_LOG2(MWL), .LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
    .req_ack(req_ack[0]), .wdata(wdata[0]), .wdata_rdy(wdata_rdy[0]), .rdata(rdata[0]),
    .rdata_vld(rdata_vld[0]), .beat_idx(beat_idx[0]), .busy(busy[0]), .done(done[0]));

  line_mem_ctrl #(.ADDR_WIDTH(32), .WORDS_PER_LINE(WPL), .MEM_WORDS_LOG2(MWL), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
    .req_ack(req_ack[1]), .wdata(wdata[1]), .wdata_rdy(wdata_rdy[1]), .rdata(rdata[1]),
    .rdata_vld(rdata_vld[1]), .beat_idx(beat_idx[1]), .busy(busy[1]), .done(done[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input int sel, input string tag);
    check({tag, " req_ack"},   32'(req_ack[sel]),   32'd0);
    check({tag, " wdata_rdy"}, 32'(wdata_rdy[sel]), 32'd0);
    check({tag, " rdata"},     rdata[sel],          32'd0);
    check({tag, " rdata_vld"}, 32'(rdata_vld[sel]), 32'd0);
    check({tag, " beat_idx"},  32'(beat_idx[sel]),  32'd0);
    check({tag, " busy"},      32'(busy[sel]),      32'd0);
    check({tag, " done"},      32'(done[sel]),      32'd0);
  endtask

  // Called just after a negedge with the DUT idle (or in its sampling IDLE cycle when req was held).
  task automatic burst(input int sel, input bit we, input logic [31:0] addr,
                       input bit hold, input int abort_beat);
    int lat, base, idx, last;
    bit beat;
    string t;
    lat  = (sel == 0) ? 4 : 1;
    base = int'((addr % MEM_WORDS) / WPL * WPL);
    last = lat + WPL + 1;
    req[sel]      = 1'b1;
    req_we[sel]   = we;
    req_addr[sel] = addr;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      beat = (n >= lat) && (n < lat + WPL);
      idx  = beat ? n - lat : 0;
      t = $sformatf("s%0d %s a=%h n=%0d", sel, we ? "wr" : "rd", addr, n);
      check({t, " req_ack"},   32'(req_ack[sel]),   32'(n == 1));
      check({t, " busy"},      32'(busy[sel]),      32'(n <= lat + WPL));
      check({t, " done"},      32'(done[sel]),      32'(n == lat + WPL));
      check({t, " beat_idx"},  32'(beat_idx[sel]),  32'(idx));
      check({t, " wdata_rdy"}, 32'(wdata_rdy[sel]), 32'(beat && we));
      check({t, " rdata_vld"}, 32'(rdata_vld[sel]), 32'(beat && !we));
      check({t, " rdata"},     rdata[sel],          (beat && !we) ? model[sel][base + idx] : 32'd0);
      if (n == 1 && !hold) req[sel] = 1'b0;
      if (beat && we && idx == abort_beat) begin
        rst = 1'b0;
        #1;
        check_zero(sel, {t, " abort"});
        @(negedge clk);
        rst = 1'b1;
        for (int m = 0; m < lat + WPL + 1; m++) begin
          @(negedge clk);
          check({t, " post-abort done"}, 32'(done[sel]), 32'd0);
          check({t, " post-abort busy"}, 32'(busy[sel]), 32'd0);
        end
        return;
      end
      if (beat && we) begin
        wdata[sel] = wbuf[idx];
        model[sel][base + idx] = wbuf[idx];
      end else begin
        wdata[sel] = $urandom;
      end
    end
  endtask

  task automatic fill_wbuf(input logic [31:0] first, input bit rnd);
    for (int i = 0; i < WPL; i++) wbuf[i] = rnd ? $urandom : first + 32'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sel, prev_sel;
    bit  we, hold, prev_hold;
    logic [31:0] a;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0; wdata[s] = '0;
    end
    repeat (3) @(negedge clk);
    check_zero(0, "reset s0");
    check_zero(1, "reset s1");
    rst = 1'b1;
    @(negedge clk);

    // Preload the 16 lines the rest of the run touches, on both instances.
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < 16; l++) begin
        fill_wbuf('0, 1'b1);
        burst(s, 1'b1, 32'(l * WPL), 1'b0, -1);
      end

    // Reset asserted mid-burst with req held high.
    req[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero(0, "midreset s0");
    check_zero(1, "midreset s1");
    @(negedge clk);
    req[0] = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("after reset busy", 32'(busy[0]), 32'd0);
      check("after reset ack", 32'(req_ack[0]), 32'd0);
    end

    fill_wbuf(32'hA0, 1'b0);
    burst(0, 1'b1, 32'h10, 1'b0, -1);
    burst(0, 1'b0, 32'h10, 1'b0, -1);

    fill_wbuf(32'hB0, 1'b0);
    burst(0, 1'b1, 32'h13, 1'b0, -1);
    burst(0, 1'b0, 32'h10, 1'b0, -1);
    burst(0, 1'b0, 32'h410, 1'b0, -1);

    burst(0, 1'b0, 32'h10, 1'b1, -1);
    burst(0, 1'b0, 32'h30, 1'b0, -1);

    fill_wbuf('0, 1'b1);
    burst(1, 1'b1, 32'h24, 1'b0, -1);
    burst(1, 1'b0, 32'h27, 1'b0, -1);
    burst(1, 1'b0, 32'h10, 1'b1, -1);
    burst(1, 1'b0, 32'h14, 1'b0, -1);

    fill_wbuf('0, 1'b0);
    burst(0, 1'b1, 32'h20, 1'b0, -1);
    fill_wbuf(32'hC0, 1'b0);
    burst(0, 1'b1, 32'h20, 1'b0, 2);
    burst(0, 1'b0, 32'h20, 1'b0, -1);

    prev_hold = 1'b0;
    prev_sel  = 0;
    for (int i = 0; i < 60; i++) begin
      sel  = prev_hold ? prev_sel : int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      hold = (i < 59) && ($urandom_range(0, 3) == 0);
      a    = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      fill_wbuf('0, 1'b1);
      burst(sel, we, a, hold, -1);
      prev_hold = hold;
      prev_sel  = sel;
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
